// File: rtl/sram_controller.sv
// Two-phase 16-bit asynchronous SRAM responder for 32-bit MEM-stage loads and stores.
// Define SRAM_CTRL_RD_CACHE_EN to enable a one-entry read cache; the default build has none.
//
// state | meaning
// IDLE  | waiting for wr_en/rd_en; ready follows the request lines
// LO    | low halfword access at {idx,0}, ACCESS_CYCLES cycles
// HI    | high halfword access at {idx,1}, ACCESS_CYCLES cycles
// DONE  | one-cycle completion, ready high, request not restarted
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          SRAM_ADDR_W   = 18,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam int               IDX_W    = SRAM_ADDR_W - 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [15:0]      lo_q, lo_d;
    logic [31:0]      read_data_q, read_data_d;

    logic [31:0]      offset;
    logic [IDX_W-1:0] req_idx;
    logic             rd_hit;
    logic             req_miss;
    logic             phase_end;
    logic             in_access;
    logic             half_hi;
    logic [31:0]      rd_word;
    logic             unused_offset_bits;

    // Word index keeps only the bits that reach the SRAM pins, so addresses wrap silently.
    assign offset             = address - BASE_ADDR;
    assign req_idx            = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

    assign phase_end = (cnt_q == CNT_LAST);
    assign in_access = (state_q == S_LO) | (state_q == S_HI);
    assign half_hi   = (state_q == S_HI);
    assign rd_word   = {SRAM_DQ, lo_q};

`ifdef SRAM_CTRL_RD_CACHE_EN
    logic             cache_vld_q, cache_vld_d;
    logic [IDX_W-1:0] cache_tag_q, cache_tag_d;
    logic [31:0]      cache_data_q, cache_data_d;

    assign rd_hit = rd_en & ~wr_en & cache_vld_q & (cache_tag_q == req_idx);

    // Fill on read completion; a store to the cached word keeps the entry coherent.
    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_tag_d  = cache_tag_q;
        cache_data_d = cache_data_q;
        if ((state_q == S_HI) && phase_end) begin
            if (!is_wr_q) begin
                cache_vld_d  = 1'b1;
                cache_tag_d  = idx_q;
                cache_data_d = rd_word;
            end else if (cache_vld_q && (cache_tag_q == idx_q)) begin
                cache_data_d = wdata_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld_q  <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_tag_q  <= cache_tag_d;
            cache_data_q <= cache_data_d;
        end
    end
`else
    assign rd_hit = 1'b0;
`endif

    assign req_miss = wr_en | (rd_en & ~rd_hit);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        read_data_d = read_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_miss) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                    is_wr_d = wr_en;
                    idx_d   = req_idx;
                    wdata_d = write_data;
                end
`ifdef SRAM_CTRL_RD_CACHE_EN
                else if (rd_hit) begin
                    read_data_d = cache_data_q;
                end
`endif
            end
            S_LO: begin
                if (phase_end) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        lo_d = SRAM_DQ;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (phase_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        read_data_d = rd_word;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            read_data_q <= read_data_d;
        end
    end

    // rst term keeps ready high during reset even if a request line is still asserted.
    assign ready = rst | (state_q == S_DONE) | ((state_q == S_IDLE) & ~req_miss);

    assign read_data = read_data_q;
    assign SRAM_ADDR = in_access ? {idx_q, half_hi} : '0;
    assign SRAM_WE_N = ~(in_access & is_wr_q);
    assign SRAM_OE_N = ~(in_access & ~is_wr_q);
    assign SRAM_DQ   = (in_access & is_wr_q) ? (half_hi ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: timeline/transaction model plus directed literal checks.
module tb_sram_controller;

    localparam int AC    = 2;
    localparam int LAST  = 2 * AC + 1;
    localparam int WORDS = 262144;
`ifdef SRAM_CTRL_RD_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif
    localparam int HIT_LOWS = CACHE_ON ? 0 : LAST;
    localparam int HIT_OES  = CACHE_ON ? 0 : 2 * AC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;

    int checks = 0;
    int errors = 0;

    sram_controller dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n),
        .SRAM_OE_N(sram_oe_n)
    );

    always #5 clk = ~clk;

    // External SRAM device
    logic [15:0] dev_mem [0:WORDS-1];
    logic [15:0] ref_mem [0:WORDS-1];

    function automatic logic [15:0] pat(int i);
        logic [31:0] t;
        t = i * 40503;
        return t[15:0] ^ 16'h3C5A;
    endfunction

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            dev_mem[i] <= pat(i);
            ref_mem[i] <= pat(i);
        end
    end

    assign sram_dq = (!sram_oe_n && sram_we_n) ? dev_mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_we_n) dev_mem[sram_addr] <= sram_dq;
    end

    // Reference model: pos = cycles since the request was accepted (0 = idle, LAST = done cycle)
    int          pos = 0;
    bit          m_wr = 1'b0;
    logic [16:0] m_idx = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_rdata = '0;
    bit          c_vld = 1'b0;
    logic [16:0] c_tag = '0;
    logic [31:0] c_data = '0;

    function automatic logic [16:0] idx_of(logic [31:0] a);
        logic [31:0] off;
        off = (a - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    function automatic bit cache_hit(logic w, logic r, logic [31:0] a);
        return CACHE_ON && r && !w && c_vld && (c_tag == idx_of(a));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= 0;
            m_rdata <= '0;
            c_vld   <= 1'b0;
        end else if (pos == 0) begin
            if (wr_en || (rd_en && !cache_hit(wr_en, rd_en, address))) begin
                pos   <= 1;
                m_wr  <= wr_en;
                m_idx <= idx_of(address);
                m_wd  <= write_data;
                if (wr_en) begin
                    ref_mem[{idx_of(address), 1'b0}] <= write_data[15:0];
                    ref_mem[{idx_of(address), 1'b1}] <= write_data[31:16];
                end
            end else if (cache_hit(wr_en, rd_en, address)) begin
                m_rdata <= c_data;
            end
        end else if (pos == LAST) begin
            pos <= 0;
        end else begin
            pos <= pos + 1;
            if (pos == 2 * AC) begin
                if (!m_wr) begin
                    m_rdata <= {ref_mem[{m_idx, 1'b1}], ref_mem[{m_idx, 1'b0}]};
                    c_vld   <= 1'b1;
                    c_tag   <= m_idx;
                    c_data  <= {ref_mem[{m_idx, 1'b1}], ref_mem[{m_idx, 1'b0}]};
                end else if (c_vld && c_tag == m_idx) begin
                    c_data <= m_wd;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        bit in_acc;
        bit hi;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", {31'd0, ready}, 32'd1);
                chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
                chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
                chk("rst_addr", {14'd0, sram_addr}, 32'd0);
                chk("rst_read_data", read_data, 32'd0);
            end else begin
                in_acc = (pos >= 1) && (pos <= 2 * AC);
                hi     = (pos > AC);
                if (pos == 0)
                    chk("ready", {31'd0, ready},
                        {31'd0, !(wr_en || (rd_en && !cache_hit(wr_en, rd_en, address)))});
                else
                    chk("ready", {31'd0, ready}, {31'd0, pos == LAST});
                chk("read_data", read_data, m_rdata);
                chk("we_n", {31'd0, sram_we_n}, {31'd0, !(in_acc && m_wr)});
                chk("oe_n", {31'd0, sram_oe_n}, {31'd0, !(in_acc && !m_wr)});
                if (in_acc) begin
                    chk("sram_addr", {14'd0, sram_addr}, {14'd0, m_idx, hi});
                    if (m_wr) chk("dq_write", {16'd0, sram_dq}, {16'd0, hi ? m_wd[31:16] : m_wd[15:0]});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input bit scramble, output int lows, output int we_lo, output int oe_lo);
        lows  = 0;
        we_lo = 0;
        oe_lo = 0;
        forever begin
            @(negedge clk);
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (ready) break;
            lows++;
            if (lows > 40) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: low for %0d cycles, required high within 40", lows);
                break;
            end
            if (scramble && lows >= 2) begin
                address    = $urandom;
                write_data = $urandom;
            end
        end
    endtask

    // Drives one request from posedge+1, returns at posedge+1 after completion with requests dropped.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input bit scramble, output int lows, output int we_lo, output int oe_lo);
        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = d;
        wait_ready(scramble, lows, we_lo, oe_lo);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        int lows, we_lo, oe_lo, lows2;
        int op;
        bit w, r;
        logic [31:0] a, d;
        logic [16:0] ix;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        chk("idle_read_data", read_data, 32'd0);
        @(posedge clk);
        #1;

        // Store 0xDEADBEEF at 1028
        txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, lows, we_lo, oe_lo);
        chk("t2_stall", lows, 32'd5);
        chk("t2_we_cycles", we_lo, 32'd4);
        chk("t2_sram2", {16'd0, dev_mem[2]}, 32'h0000BEEF);
        chk("t2_sram3", {16'd0, dev_mem[3]}, 32'h0000DEAD);

        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lows, we_lo, oe_lo);
        chk("t3_stall", lows, 32'd5);
        chk("t3_oe_cycles", oe_lo, 32'd4);
        chk("t3_read_data", read_data, 32'hDEADBEEF);

        // Both requests set: write wins, load result untouched
        txn(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, lows, we_lo, oe_lo);
        chk("t4_sram4", {16'd0, dev_mem[4]}, 32'h00005678);
        chk("t4_sram5", {16'd0, dev_mem[5]}, 32'h00001234);
        chk("t4_oe_cycles", oe_lo, 32'd0);
        chk("t4_read_data", read_data, 32'hDEADBEEF);

        // Back-to-back reads with rd_en held
        txn(1'b1, 1'b0, 32'd1024, 32'hA5A50001, 1'b0, lows, we_lo, oe_lo);
        txn(1'b1, 1'b0, 32'd1036, 32'h5A5A0003, 1'b0, lows, we_lo, oe_lo);
        rd_en   = 1'b1;
        address = 32'd1024;
        wait_ready(1'b0, lows, we_lo, oe_lo);
        chk("t5_stall_a", lows, 32'd5);
        chk("t5_read_a", read_data, 32'hA5A50001);
        address = 32'd1036;
        wait_ready(1'b0, lows2, we_lo, oe_lo);
        chk("t5_stall_b", lows2, 32'd5);
        chk("t5_read_b", read_data, 32'h5A5A0003);
        @(posedge clk);
        #1 rd_en = 1'b0;

        // Repeated read of one word, then a store to it
        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lows, we_lo, oe_lo);
        chk("t6_first_stall", lows, 32'd5);
        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lows, we_lo, oe_lo);
        chk("t6_second_stall", lows, HIT_LOWS);
        chk("t6_second_oe", oe_lo, HIT_OES);
        chk("t6_second_data", read_data, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 1'b0, lows, we_lo, oe_lo);
        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lows, we_lo, oe_lo);
        chk("t6_after_write_stall", lows, HIT_LOWS);
        chk("t6_after_write_data", read_data, 32'h0BADF00D);

        // Reset during cycle 2 of the low phase of a store
        wr_en      = 1'b1;
        address    = 32'd1028;
        write_data = 32'h11112222;
        @(posedge clk);
        @(posedge clk);
        #1 chk("t1_midwrite_we_n", {31'd0, sram_we_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("t1_ready", {31'd0, ready}, 32'd1);
        chk("t1_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("t1_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("t1_read_data", read_data, 32'd0);
        chk("t1_addr", {14'd0, sram_addr}, 32'd0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 1'b0, lows, we_lo, oe_lo);
        txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lows, we_lo, oe_lo);
        chk("t1_after_reset_stall", lows, 32'd5);
        chk("t1_after_reset_data", read_data, 32'hCAFEF00D);

        // Randomized traffic, including wrapped addresses and mid-access input changes
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 9) a = $urandom;
            else a = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            d = $urandom;
            w = (op <= 2) || (op == 6);
            r = (op >= 3 && op <= 6);
            txn(w, r, a, d, 1'($urandom_range(0, 1)), lows, we_lo, oe_lo);
            if (w) begin
                ix = idx_of(a);
                chk("rand_sram_lo", {16'd0, dev_mem[{ix, 1'b0}]}, {16'd0, d[15:0]});
                chk("rand_sram_hi", {16'd0, dev_mem[{ix, 1'b1}]}, {16'd0, d[31:16]});
            end
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
